// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage; restoring, one quotient bit per cycle.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             ex_hold,
   input  logic             op_valid,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             stallreq_ex,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic             q_neg;
   logic             r_neg;
   logic             sel_rem;

   logic             a_neg;
   logic             b_neg;
   logic             div_zero;
   logic             ovf;
   logic             early;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

   // Stall while a divide is outstanding; a flush releases the pipeline in the same cycle.
   assign stallreq_ex = rst_n & op_valid & (state != DONE) & ~flush;

   // Operand decode: magnitudes, signs and the one-cycle special cases.
   always_comb begin
      a_neg    = ~op[0] & rs1[WIDTH-1];
      b_neg    = ~op[0] & rs2[WIDTH-1];
      a_mag    = a_neg ? (~rs1 + WIDTH'(1)) : rs1;
      b_mag    = b_neg ? (~rs2 + WIDTH'(1)) : rs2;
      div_zero = (rs2 == '0);
      ovf      = ~op[0] & (rs1 == MIN_NEG) & (rs2 == '1);
`ifdef DIV_EARLY_OUT_EN
      early    = ~div_zero & ~ovf & (a_mag < b_mag);
`else
      early    = 1'b0;
`endif
   end

   // One restoring step plus the sign-corrected final values.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      if (!trial[WIDTH]) begin
         rem_nx = trial[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_nx = shifted[WIDTH-1:0];
         quo_nx = {quo[WIDTH-2:0], 1'b0};
      end
      q_fin = q_neg ? (~quo_nx + WIDTH'(1)) : quo_nx;
      r_fin = r_neg ? (~rem_nx + WIDTH'(1)) : rem_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         counter      <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         quo          <= '0;
         rem          <= '0;
         dvs          <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         sel_rem      <= 1'b0;
      end else if (flush) begin
         state        <= IDLE;
         counter      <= '0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid) begin
                  sel_rem <= op[1];
                  if (div_zero) begin
                     result       <= op[1] ? rs1 : '1;
                     result_valid <= 1'b1;
                     state        <= DONE;
                  end else if (ovf) begin
                     result       <= op[1] ? '0 : MIN_NEG;
                     result_valid <= 1'b1;
                     state        <= DONE;
                  end else if (early) begin
                     result       <= op[1] ? rs1 : '0;
                     result_valid <= 1'b1;
                     state        <= DONE;
                  end else begin
                     quo     <= a_mag;
                     dvs     <= b_mag;
                     rem     <= '0;
                     q_neg   <= a_neg ^ b_neg;
                     r_neg   <= a_neg;
                     counter <= '0;
                     state   <= CALC;
                  end
               end
            end
            CALC: begin
               quo     <= quo_nx;
               rem     <= rem_nx;
               counter <= counter + CW'(1);
               if (counter == CW'(WIDTH-1)) begin
                  result       <= sel_rem ? r_fin : q_fin;
                  result_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               // Result is held until the EX instruction advances.
               if (!ex_hold) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed + random bench for div_unit with a result scoreboard and a reference divide model.
module tb_div_unit;
   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         ex_hold;
   logic         op_valid;
   logic [1:0]   op;
   logic [W-1:0] rs1;
   logic [W-1:0] rs2;
   logic         stallreq_ex;
   logic [W-1:0] result;
   logic         result_valid;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] sb_q[$];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_hold(ex_hold),
      .op_valid(op_valid), .op(op), .rs1(rs1), .rs2(rs2),
      .stallreq_ex(stallreq_ex), .result(result), .result_valid(result_valid)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      if (b == '0) return o[1] ? a : '1;
      if (!o[0] && a == 32'h8000_0000 && b == '1) return o[1] ? '0 : a;
      case (o)
         2'b00:   return W'(sa / sb);
         2'b01:   return a / b;
         2'b10:   return W'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == '1) return 1;
`ifdef DIV_EARLY_OUT_EN
      begin
         logic [W-1:0] ma;
         logic [W-1:0] mb;
         ma = (!o[0] && a[W-1]) ? (~a + W'(1)) : a;
         mb = (!o[0] && b[W-1]) ? (~b + W'(1)) : b;
         if (ma < mb) return 1;
      end
`endif
      return W + 1;
   endfunction

   // Issue one op, count stall cycles until result_valid, compare against the scoreboard, then retire.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int hold);
      int stalls;
      int lat;
      bit seen;
      logic [W-1:0] e;
      stalls = 0;
      seen   = 1'b0;
      e      = '0;
      lat    = ref_lat(o, a, b);
      sb_q.push_back(exp);
      @(posedge clk); #1;
      op_valid = 1'b1; op = o; rs1 = a; rs2 = b;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
         else if (stallreq_ex) stalls++;
      end
      chk({tag, "_done"}, W'(seen), W'(1));
      if (sb_q.size() > 0) e = sb_q.pop_front();
      if (seen) begin
         chk({tag, "_result"}, result, e);
         chk({tag, "_stall_cycles"}, W'(stalls), W'(lat));
         chk({tag, "_stall_in_done"}, W'(stallreq_ex), W'(0));
      end
      ex_hold = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_hold_valid"}, W'(result_valid), W'(1));
         chk({tag, "_hold_result"}, result, e);
         chk({tag, "_hold_stall"}, W'(stallreq_ex), W'(0));
      end
      ex_hold = 1'b0;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_retired"}, W'(result_valid), W'(0));
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
      op_valid = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;

      // Reset state, with a pending op that must not raise a stall.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", W'(stallreq_ex), W'(0));
      chk("reset_valid", W'(result_valid), W'(0));
      chk("reset_result", result, '0);
      @(posedge clk); #1;
      rst_n = 1'b1; op_valid = 1'b0;

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 0);
      run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
      run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);
      run_op("div_by_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      run_op("remu_by_0", 2'b11, 32'd5, 32'd0, 32'd5, 0);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
      run_op("divu_hold", 2'b01, 32'd1000, 32'd10, 32'd100, 3);
      run_op("divu_3_10", 2'b01, 32'd3, 32'd10, 32'd0, 0);
      run_op("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 0);
      run_op("div_neg_neg", 2'b00, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'd16, 0);
      run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 0);

      // Flush during CALC: stall drops immediately, no result follows.
      @(posedge clk); #1;
      op_valid = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd7;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", W'(stallreq_ex), W'(0));
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", W'(result_valid), W'(0));
      chk("flush_idle_stall", W'(stallreq_ex), W'(0));
      run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 0);

      // Reset in the middle of CALC aborts and clears the result.
      @(posedge clk); #1;
      op_valid = 1'b1; op = 2'b01; rs1 = 32'd5000; rs2 = 32'd7;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_stall", W'(stallreq_ex), W'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; op_valid = 1'b0;
      @(negedge clk);
      chk("midrst_valid", W'(result_valid), W'(0));
      chk("midrst_result", result, '0);
      run_op("after_rst", 2'b00, 32'd77, 32'hFFFF_FFF9, 32'hFFFF_FFF5, 0);

      // Random operands against the reference model.
      for (int k = 0; k < 8; k++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (k % 2 == 0) ? W'($urandom_range(1, 300)) : $urandom;
         if (k % 4 == 1) rb = ~rb + W'(1);
         run_op("rand", ro, ra, rb, ref_res(ro, ra, rb), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
